dhcp_vlg_client_ctrl: RTL

DHCP client sequencer sitting between the user-side address request and the `dhcp_vlg_rx`/`dhcp_vlg_tx` message datapath. It drives the DISCOVER→OFFER→REQUEST→ACK exchange with per-message timeouts and bounded retries, then holds the lease. It runs T1 renewal and T2 rebinding timers and drops the address on expiry or NAK. It publishes the bound IPv4 address to the IP layer.

---
 rtl/dhcp_vlg_client_ctrl_if.sv | 33 +++
 rtl/dhcp_vlg_client_ctrl.sv | 241 ++++++++++++++++++++++++
 2 files changed

// File: rtl/dhcp_vlg_client_ctrl_if.sv
// DHCP message bus between the client controller and the dhcp_vlg_rx/dhcp_vlg_tx datapath.
// master: outbound request fields plus val strobe; slave: parsed reply fields, sink answers with done.
interface dhcp_vlg_client_ctrl_if;
  logic        val;
  logic        done;
  logic [7:0]  op;
  logic [31:0] xid;
  logic [47:0] chaddr;
  logic [7:0]  msg_type;
  logic [31:0] src_ip;
  logic [31:0] dst_ip;
  logic [31:0] req_ip;
  logic        req_ip_pres;
  logic [31:0] server_id;
  logic        server_id_pres;
  logic [31:0] yiaddr;
  logic [31:0] lease;
  logic [31:0] t1;
  logic        t1_pres;
  logic [31:0] t2;
  logic        t2_pres;

  modport master (
    output val, op, xid, chaddr, msg_type, src_ip, dst_ip,
           req_ip, req_ip_pres, server_id, server_id_pres
  );

  modport slave (
    input  val, op, xid, chaddr, msg_type, yiaddr, server_id,
           lease, t1, t1_pres, t2, t2_pres,
    output done
  );
endinterface

// File: rtl/dhcp_vlg_client_ctrl.sv
// DHCP client sequencer: DISCOVER/OFFER/REQUEST/ACK with timeouts and retries, then lease hold.
// Lease timers (T1 renew, T2 rebind, expiry) are built only with DHCP_VLG_LEASE_RENEW_EN defined.
module dhcp_vlg_client_ctrl #(
  parameter logic [47:0] MAC_ADDR      = '0,
  parameter int unsigned TIMEOUT_TICKS = 1_250_000,
  parameter int unsigned RETRIES       = 3,
  parameter int unsigned TICK_DIV      = 125_000_000,
  parameter logic [31:0] XID_SEED      = 32'h4E59_0001
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          ipv4_req,
  input  logic [31:0]                   pref_ipv4,
  output logic [31:0]                   ipv4_addr,
  output logic                          ipv4_val,
  output logic                          ok,
  output logic                          timeout,
  dhcp_vlg_client_ctrl_if.slave         rx,
  dhcp_vlg_client_ctrl_if.master        tx
);

  localparam logic [31:0] TMO         = 32'(TIMEOUT_TICKS);
  localparam logic [31:0] RETRY_LIM   = 32'(RETRIES);
  localparam logic [7:0]  MT_DISCOVER = 8'd1;
  localparam logic [7:0]  MT_OFFER    = 8'd2;
  localparam logic [7:0]  MT_REQUEST  = 8'd3;
  localparam logic [7:0]  MT_ACK      = 8'd5;
  localparam logic [7:0]  MT_NAK      = 8'd6;

  typedef enum logic [3:0] {
    ST_IDLE, ST_DISCOVER, ST_WAIT_OFFER, ST_REQUEST, ST_WAIT_ACK,
    ST_BOUND, ST_RENEW, ST_WAIT_RENEW, ST_REBIND, ST_WAIT_REBIND
  } state_t;

  state_t      state;
  logic [31:0] xid, xid_nxt, retry_cnt, tmr, offer_ip, srv_id;
  logic        req_q;
  logic        rx_hit, rx_offer, rx_ack, rx_nak, in_wait, ack_wait, tmr_zero, can_retry;

`ifdef DHCP_VLG_LEASE_RENEW_EN
  localparam logic [31:0] DIV_LAST = 32'(TICK_DIV - 1);
  logic [31:0] lease_len, t1, t2, lease_sec, div_cnt;
  logic        lease_exp, t1_hit, t2_hit;

  // T1 at or beyond the lease collapses to immediate expiry out of BOUND.
  always_comb begin
    lease_exp = ipv4_val && ((lease_sec >= lease_len) || (state == ST_BOUND && t1 >= lease_len));
    t1_hit    = lease_sec >= t1;
    t2_hit    = lease_sec >= t2;
  end
`endif

  always_comb begin
    rx_hit    = rx.val && rx.op == 8'd2 && rx.xid == xid && rx.chaddr == MAC_ADDR;
    rx_offer  = rx_hit && rx.msg_type == MT_OFFER;
    rx_ack    = rx_hit && rx.msg_type == MT_ACK;
    rx_nak    = rx_hit && rx.msg_type == MT_NAK;
    in_wait   = state inside {ST_WAIT_OFFER, ST_WAIT_ACK, ST_WAIT_RENEW, ST_WAIT_REBIND};
    ack_wait  = in_wait && state != ST_WAIT_OFFER;
    tmr_zero  = tmr == '0;
    can_retry = retry_cnt < RETRY_LIM;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= ST_IDLE;
      xid       <= XID_SEED;
      xid_nxt   <= XID_SEED;
      retry_cnt <= '0;
      tmr       <= '0;
      req_q     <= 1'b0;
      offer_ip  <= '0;
      srv_id    <= '0;
      ipv4_addr <= '0;
      ipv4_val  <= 1'b0;
      ok        <= 1'b0;
      timeout   <= 1'b0;
      rx.done   <= 1'b0;
      tx.val    <= 1'b0;
      tx.op     <= '0;
      tx.xid    <= '0;
      tx.chaddr <= '0;
      tx.msg_type       <= '0;
      tx.src_ip         <= '0;
      tx.dst_ip         <= '0;
      tx.req_ip         <= '0;
      tx.req_ip_pres    <= 1'b0;
      tx.server_id      <= '0;
      tx.server_id_pres <= 1'b0;
`ifdef DHCP_VLG_LEASE_RENEW_EN
      lease_len <= '0;
      t1        <= '0;
      t2        <= '0;
      lease_sec <= '0;
      div_cnt   <= '0;
`endif
    end else begin
      tx.val    <= 1'b0;
      ok        <= 1'b0;
      timeout   <= 1'b0;
      rx.done   <= rx.val;
      req_q     <= ipv4_req;
      tx.op     <= 8'd1;
      tx.chaddr <= MAC_ADDR;
      if (!tmr_zero) tmr <= tmr - 32'd1;
`ifdef DHCP_VLG_LEASE_RENEW_EN
      if (ipv4_val) begin
        if (div_cnt == DIV_LAST) begin
          div_cnt   <= '0;
          lease_sec <= lease_sec + 32'd1;
        end else begin
          div_cnt <= div_cnt + 32'd1;
        end
      end
      // Expiry outranks every other transition, hence the else chained across the guard.
      if (lease_exp) begin
        ipv4_val  <= 1'b0;
        state     <= ST_DISCOVER;
        xid       <= xid_nxt;
        xid_nxt   <= xid_nxt + 32'd1;
        retry_cnt <= '0;
      end else
`endif
      if (rx_nak && in_wait) begin
        ipv4_val  <= 1'b0;
        ipv4_addr <= '0;
        state     <= ST_DISCOVER;
        xid       <= xid_nxt;
        xid_nxt   <= xid_nxt + 32'd1;
        retry_cnt <= '0;
      end else if (rx_ack && ack_wait) begin
        ipv4_addr <= rx.yiaddr;
        ipv4_val  <= 1'b1;
        ok        <= 1'b1;
        state     <= ST_BOUND;
`ifdef DHCP_VLG_LEASE_RENEW_EN
        lease_len <= rx.lease;
        t1        <= rx.t1_pres ? rx.t1 : rx.lease >> 1;
        t2        <= rx.t2_pres ? rx.t2 : rx.lease - (rx.lease >> 3);
        lease_sec <= '0;
        div_cnt   <= '0;
`endif
      end else begin
        case (state)
          ST_IDLE: if (ipv4_req && !req_q) begin
            state     <= ST_DISCOVER;
            xid       <= xid_nxt;
            xid_nxt   <= xid_nxt + 32'd1;
            retry_cnt <= '0;
          end
          ST_DISCOVER: begin
            tx.val            <= 1'b1;
            tx.xid            <= xid;
            tx.msg_type       <= MT_DISCOVER;
            tx.src_ip         <= '0;
            tx.dst_ip         <= '1;
            tx.req_ip         <= pref_ipv4;
            tx.req_ip_pres    <= |pref_ipv4;
            tx.server_id      <= '0;
            tx.server_id_pres <= 1'b0;
            tmr               <= TMO;
            retry_cnt         <= retry_cnt + 32'd1;
            state             <= ST_WAIT_OFFER;
          end
          ST_WAIT_OFFER: begin
            if (rx_offer) begin
              offer_ip  <= rx.yiaddr;
              srv_id    <= rx.server_id;
              retry_cnt <= '0;
              state     <= ST_REQUEST;
            end else if (tmr_zero) begin
              if (can_retry) state <= ST_DISCOVER;
              else begin
                timeout  <= 1'b1;
                ipv4_val <= 1'b0;
                state    <= ST_IDLE;
              end
            end
          end
          ST_REQUEST: begin
            tx.val            <= 1'b1;
            tx.xid            <= xid;
            tx.msg_type       <= MT_REQUEST;
            tx.src_ip         <= '0;
            tx.dst_ip         <= '1;
            tx.req_ip         <= offer_ip;
            tx.req_ip_pres    <= 1'b1;
            tx.server_id      <= srv_id;
            tx.server_id_pres <= 1'b1;
            tmr               <= TMO;
            retry_cnt         <= retry_cnt + 32'd1;
            state             <= ST_WAIT_ACK;
          end
          ST_WAIT_ACK: if (tmr_zero) begin
            if (can_retry) state <= ST_REQUEST;
            else begin
              timeout  <= 1'b1;
              ipv4_val <= 1'b0;
              state    <= ST_IDLE;
            end
          end
`ifdef DHCP_VLG_LEASE_RENEW_EN
          ST_BOUND: if (t1_hit) state <= ST_RENEW;
          ST_RENEW: begin
            if (t2_hit) state <= ST_REBIND;
            else begin
              tx.val            <= 1'b1;
              tx.xid            <= xid;
              tx.msg_type       <= MT_REQUEST;
              tx.src_ip         <= ipv4_addr;
              tx.dst_ip         <= srv_id;
              tx.req_ip_pres    <= 1'b0;
              tx.server_id_pres <= 1'b0;
              tmr               <= TMO;
              state             <= ST_WAIT_RENEW;
            end
          end
          ST_WAIT_RENEW: begin
            if (t2_hit) state <= ST_REBIND;
            else if (tmr_zero) state <= ST_RENEW;
          end
          ST_REBIND: begin
            tx.val            <= 1'b1;
            tx.xid            <= xid;
            tx.msg_type       <= MT_REQUEST;
            tx.src_ip         <= '0;
            tx.dst_ip         <= '1;
            tx.req_ip_pres    <= 1'b0;
            tx.server_id_pres <= 1'b0;
            tmr               <= TMO;
            state             <= ST_WAIT_REBIND;
          end
          ST_WAIT_REBIND: if (tmr_zero) state <= ST_REBIND;
`endif
          default: ;
        endcase
      end
    end
  end

endmodule
